csel_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. It is the next generation of the team's 8-bit combinational carry-select adder.
- Operand width is split into BLK-bit blocks. One block is resolved per pipeline stage, using the carry registered by the previous stage.
- Adds an ADD/SUB mode, a signed-overflow flag and valid/ready handshakes on both sides.
- Sits in datapath units that need wide adds at high clock rates with a fixed latency.

---
 rtl/csel_pkg.sv | 15 +
 rtl/csel_adder_pipe_if.sv | 30 +++
 rtl/csel_block.sv | 39 +++
 rtl/csel_adder_pipe.sv | 122 ++++++++++++
 tb/tb_csel_adder_pipe.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csel_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder/subtractor.
package csel_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned BLK_DEF   = 8;

  // One block resolved per stage, so stage count equals the block count
  function automatic int unsigned calc_nstg(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

endpackage

// File: rtl/csel_adder_pipe_if.sv
// Operand/result handshake bundle for csel_adder_pipe.
interface csel_adder_pipe_if
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/csel_block.sv
// Combinational BLK-bit carry-select slice: both carry-in cases rippled in parallel, then selected.
module csel_block
  import csel_pkg::*;
#(
  parameter int unsigned BLK = BLK_DEF
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] bx,
  input  logic           csel,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK-1:0] p;
  logic [BLK-1:0] g;
  logic [BLK-1:0] s0;
  logic [BLK-1:0] s1;
  logic [BLK:0]   c0;
  logic [BLK:0]   c1;

  always_comb begin
    p  = a ^ bx;
    g  = a & bx;
    s0 = '0;
    s1 = '0;
    c0 = '0;
    c1 = '0;
    c1[0] = 1'b1;
    for (int unsigned i = 0; i < BLK; i++) begin
      s0[i]   = p[i] ^ c0[i];
      c0[i+1] = g[i] | (p[i] & c0[i]);
      s1[i]   = p[i] ^ c1[i];
      c1[i+1] = g[i] | (p[i] & c1[i]);
    end
    sum  = csel ? s1 : s0;
    cout = csel ? c1[BLK] : c0[BLK];
  end

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one BLK-bit block resolved per stage,
// unresolved operand blocks skewed down the pipe, single global stall enable.
module csel_adder_pipe
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned BLK   = BLK_DEF
) (
  input logic               clk,
  input logic               rst_n,
  csel_adder_pipe_if.slave  bus
);

  localparam int unsigned NSTG = calc_nstg(WIDTH, BLK);

  if ((WIDTH % BLK) != 0) begin : g_bad_cfg
    $error("csel_adder_pipe: WIDTH must be a multiple of BLK");
  end

  logic             en;
  logic [WIDTH-1:0] bx_in;

  // Effective B operand, inverted for subtract
  always_comb begin
    bx_in = bus.b;
    unique case (bus.op)
      OP_ADD:  bx_in = bus.b;
      OP_SUB:  bx_in = ~bus.b;
      default: bx_in = bus.b;
    endcase
  end

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned LO = k * BLK;
    localparam int unsigned RW = WIDTH - LO;

    logic              src_v;
    logic              src_c;
    logic              src_am;
    logic              src_bm;
    logic [RW-1:0]     src_a;
    logic [RW-1:0]     src_bx;
    logic [LO+BLK-1:0] s_d;
    logic [BLK-1:0]    blk_sum;
    logic              blk_cout;

    logic              v_q;
    logic              c_q;
    logic              am_q;
    logic              bm_q;
    logic [LO+BLK-1:0] s_q;

    // Stage 0 takes fresh operands; later stages take the previous stage's leftovers
    if (k == 0) begin : g_src
      assign src_v  = bus.in_valid;
      assign src_c  = bus.cin;
      assign src_a  = bus.a;
      assign src_bx = bx_in;
      assign src_am = bus.a[WIDTH-1];
      assign src_bm = bx_in[WIDTH-1];
      assign s_d    = blk_sum;
    end else begin : g_src
      assign src_v  = g_stg[k-1].v_q;
      assign src_c  = g_stg[k-1].c_q;
      assign src_a  = g_stg[k-1].g_rem.ra_q;
      assign src_bx = g_stg[k-1].g_rem.rb_q;
      assign src_am = g_stg[k-1].am_q;
      assign src_bm = g_stg[k-1].bm_q;
      assign s_d    = {blk_sum, g_stg[k-1].s_q};
    end

    csel_block #(.BLK(BLK)) u_blk (
      .a    (src_a[BLK-1:0]),
      .bx   (src_bx[BLK-1:0]),
      .csel (src_c),
      .sum  (blk_sum),
      .cout (blk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        am_q <= 1'b0;
        bm_q <= 1'b0;
        s_q  <= '0;
      end else if (en) begin
        v_q  <= src_v;
        c_q  <= blk_cout;
        am_q <= src_am;
        bm_q <= src_bm;
        s_q  <= s_d;
      end
    end

    // Operand blocks still waiting for a later stage
    if (k < NSTG - 1) begin : g_rem
      logic [RW-BLK-1:0] ra_q;
      logic [RW-BLK-1:0] rb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (en) begin
          ra_q <= src_a[RW-1:BLK];
          rb_q <= src_bx[RW-1:BLK];
        end
      end
    end
  end

  // Whole pipe advances unless a held result is being refused
  assign en            = !g_stg[NSTG-1].v_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = g_stg[NSTG-1].v_q;
  assign bus.sum       = g_stg[NSTG-1].s_q;
  assign bus.cout      = g_stg[NSTG-1].c_q;
  assign bus.ovf       = (g_stg[NSTG-1].am_q == g_stg[NSTG-1].bm_q) &&
                         (g_stg[NSTG-1].s_q[WIDTH-1] != g_stg[NSTG-1].am_q);

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe: a 32/8 instance (directed, backpressure, reset)
// and a 12/4 instance (random stream), both checked against an arithmetic reference.
module tb_csel_adder_pipe;
  import csel_pkg::*;

  localparam int unsigned W0 = 32, B0 = 8, N0 = 4;
  localparam int unsigned W1 = 12, B1 = 4, N1 = 3;
  localparam int MAXC = 20000;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          edg;
  } exp_t;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  always #5 clk = ~clk;

  csel_adder_pipe_if #(.WIDTH(W0)) bus0 ();
  csel_adder_pipe_if #(.WIDTH(W1)) bus1 ();

  csel_adder_pipe #(.WIDTH(W0), .BLK(B0)) u_dut0 (.clk(clk), .rst_n(rst0_n), .bus(bus0));
  csel_adder_pipe #(.WIDTH(W1), .BLK(B1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  exp_t        q[2][$];
  bit          frz[2][MAXC];
  bit          seen[2];
  bit          hold_v[2];
  logic [34:0] hold_d[2];
  bit          fin_req = 1'b0;
  bit          fin_ack = 1'b0;
  bit          done1   = 1'b0;
  bit          rnd0_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic exp_t model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic op);
    exp_t   e;
    longint m, ua, ub, sa, sb, t, sr, ci;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    ci = longint'(cin);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (op == OP_ADD) begin
      t      = ua + ub + ci;
      e.cout = (t >= m);
      sr     = sa + sb + ci;
    end else begin
      t      = ua - ub - 1 + ci;
      e.cout = (t >= 0);
      sr     = sa - sb - 1 + ci;
    end
    e.sum = 32'(((t % m) + m) % m);
    e.ovf = (sr >= m / 2) || (sr < -(m / 2));
    e.edg = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %0h, expected %0h", name, d, cyc, got, exp);
    end
  endtask

  task automatic mon(input int d, input logic rst_n, input logic ov, input logic ordy, input logic irdy,
                     input logic [31:0] s, input logic c, input logic o, input int nstg);
    exp_t e;
    int   nf;
    if (!rst_n) begin
      chk("reset_out_valid", d, 64'(ov), 64'(0));
      q[d].delete();
      seen[d]   = 1'b0;
      hold_v[d] = 1'b0;
      return;
    end
    chk("in_ready", d, 64'(irdy), 64'(!ov || ordy));
    if (hold_v[d]) chk("held_output_stable", d, 64'({ov, c, o, s}), 64'(hold_d[d]));
    if (q[d].size() == 0) begin
      chk("no_spurious_valid", d, 64'(ov), 64'(0));
      hold_v[d] = 1'b0;
    end else if (ov) begin
      e = q[d][0];
      if (!seen[d]) begin
        nf = 0;
        for (int i = e.edg + 1; i <= cyc && i < MAXC; i++) nf += int'(frz[d][i]);
        chk("latency", d, 64'(cyc), 64'(e.edg + nstg - 1 + nf));
        chk("result", d, 64'({c, o, s}), 64'({e.cout, e.ovf, e.sum}));
        seen[d] = 1'b1;
      end
      if (ordy) begin
        void'(q[d].pop_front());
        seen[d]   = 1'b0;
        hold_v[d] = 1'b0;
      end else begin
        hold_v[d] = 1'b1;
        hold_d[d] = {ov, c, o, s};
      end
    end else begin
      hold_v[d] = 1'b0;
    end
    if (cyc + 1 < MAXC) frz[d][cyc+1] = !irdy;
  endtask

  // Monitor: the only place results are compared
  always @(negedge clk) begin
    mon(0, rst0_n, bus0.out_valid, bus0.out_ready, bus0.in_ready, bus0.sum, bus0.cout, bus0.ovf, N0);
    mon(1, rst1_n, bus1.out_valid, bus1.out_ready, bus1.in_ready, 32'(bus1.sum), bus1.cout, bus1.ovf, N1);
    if (fin_req && !fin_ack) begin
      chk("drain_empty", 0, 64'(q[0].size()), 64'(0));
      chk("drain_empty", 1, 64'(q[1].size()), 64'(0));
      fin_ack = 1'b1;
    end
  end

  task automatic send(input int d, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic op, input exp_t e);
    int t;
    @(posedge clk); #1;
    if (d == 0) begin
      bus0.in_valid = 1'b1; bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.op = op;
    end else begin
      bus1.in_valid = 1'b1; bus1.a = a[11:0]; bus1.b = b[11:0]; bus1.cin = cin; bus1.op = op;
    end
    t = 0;
    while (1) begin
      @(negedge clk);
      if ((d == 0) ? bus0.in_ready : bus1.in_ready) break;
      t++;
      if (t > 1000) begin
        $display("FAIL send_timeout dut%0d: in_ready stayed 0, expected 1 within 1000 cycles", d);
        $fatal(1);
      end
      @(posedge clk); #1;
    end
    e.edg = cyc + 1;
    q[d].push_back(e);
  endtask

  task automatic send_ref(input int d, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic op);
    send(d, a, b, cin, op, model((d == 0) ? W0 : W1, a, b, cin, op));
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (d == 0) bus0.in_valid = 1'b0; else bus1.in_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] mask);
    logic [31:0] h;
    h = mask >> 1;
    case ($urandom_range(7))
      0:       return 32'(0);
      1:       return mask;
      2:       return h;
      3:       return h + 32'(1);
      default: return $urandom & mask;
    endcase
  endfunction

  task automatic rnd(input int d);
    logic [31:0] mask;
    mask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_0FFF;
    send_ref(d, pick(mask), pick(mask), 1'($urandom_range(1)), 1'($urandom_range(1)));
  endtask

  task automatic wait_valid0();
    int t;
    t = 0;
    while (!bus0.out_valid) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        $display("FAIL wait_out_valid dut0: out_valid stayed 0, expected 1 within 100 cycles");
        $fatal(1);
      end
    end
  endtask

  task automatic seq0();
    exp_t e;
    // Directed corner vectors with hand-derived expectations
    e = '{sum: 32'h0000_0000, cout: 1'b1, ovf: 1'b0, edg: 0};
    send(0, 32'hFFFF_FFFF, 32'h0, 1'b1, OP_ADD, e);
    idle(0, 6);
    e = '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, edg: 0};
    send(0, 32'd5, 32'd7, 1'b1, OP_SUB, e);
    e = '{sum: 32'h0000_0002, cout: 1'b1, ovf: 1'b0, edg: 0};
    send(0, 32'd7, 32'd5, 1'b1, OP_SUB, e);
    e = '{sum: 32'h8000_0000, cout: 1'b0, ovf: 1'b1, edg: 0};
    send(0, 32'h7FFF_FFFF, 32'd1, 1'b0, OP_ADD, e);
    e = '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, edg: 0};
    send(0, 32'h8000_0000, 32'd1, 1'b1, OP_SUB, e);
    idle(0, 6);

    // Six back-to-back beats with a three-cycle output stall
    fork
      begin
        for (int i = 0; i < 6; i++) rnd(0);
        idle(0, 1);
      end
      begin
        @(negedge clk);
        wait_valid0();
        @(posedge clk); #1 bus0.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus0.out_ready = 1'b1;
      end
    join
    idle(0, 8);

    // Random stream with random backpressure
    rnd0_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(4) == 0) idle(0, 1);
      rnd(0);
    end
    rnd0_on = 1'b0;
    idle(0, 2);
    @(posedge clk); #1 bus0.out_ready = 1'b1;
    idle(0, 12);

    // Reset with beats in flight and one result held at the output
    @(posedge clk); #1 bus0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) rnd(0);
    idle(0, 1);
    @(negedge clk);
    wait_valid0();
    @(posedge clk); #2 rst0_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst0_n = 1'b1;
    bus0.out_ready = 1'b1;
    idle(0, 10);
  endtask

  task automatic seq1();
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(3) == 0) idle(1, 1);
          rnd(1);
        end
        idle(1, 1);
        done1 = 1'b1;
      end
      begin
        while (!done1) begin
          @(posedge clk); #1 bus1.out_ready = ($urandom_range(3) != 0);
        end
        bus1.out_ready = 1'b1;
      end
    join
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd0_on) bus0.out_ready = ($urandom_range(3) != 0);
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.op = OP_ADD;
    bus0.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.op = OP_ADD;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst0_n = 1'b1; rst1_n = 1'b1;
    fork
      seq0();
      seq1();
    join
    repeat (20) @(posedge clk);
    fin_req = 1'b1;
    for (int t = 0; t < 5 && !fin_ack; t++) @(negedge clk);
    #1;
    if (!fin_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL final_handshake: monitor acknowledge 0, expected 1");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
